zap_regf_wb_scheduler: RTL and testbench



---
 rtl/zap_regf_wb_scheduler_pkg.sv | 14 +
 rtl/zap_regf_wb_scheduler_if.sv | 30 +++
 rtl/zap_regf_pick2.sv | 53 +++++
 rtl/zap_regf_wb_scheduler.sv | 140 ++++++++++++++
 tb/tb_zap_regf_wb_scheduler.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/zap_regf_wb_scheduler_pkg.sv
// Shared widths, requester indices and FSM encoding for the register-file
// write-back scheduler.
package zap_regf_sched_pkg;
  localparam int ADDR_W  = 6;
  localparam int DATA_W  = 32;
  localparam int NUM_REQ = 3;

  localparam int REQ_LOAD = 0;
  localparam int REQ_ALU  = 1;
  localparam int REQ_BASE = 2;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;
endpackage

// File: rtl/zap_regf_wb_scheduler_if.sv
// Requester handshake plus register-file write bus of the write-back scheduler.
interface zap_regf_wb_scheduler_if;
  import zap_regf_sched_pkg::*;

  logic [NUM_REQ-1:0]        i_req_valid;
  logic [NUM_REQ*ADDR_W-1:0] i_req_addr;
  logic [NUM_REQ*DATA_W-1:0] i_req_data;
  logic [NUM_REQ-1:0]        o_req_ready;
  logic                      o_wen;
  logic [ADDR_W-1:0]         o_wr_addr_a;
  logic [ADDR_W-1:0]         o_wr_addr_b;
  logic [DATA_W-1:0]         o_wr_data_a;
  logic [DATA_W-1:0]         o_wr_data_b;
  logic                      o_clear_done;
  logic                      o_addr_err;

  // Requester / register-file side.
  modport master (
    output i_req_valid, i_req_addr, i_req_data,
    input  o_req_ready, o_wen, o_wr_addr_a, o_wr_addr_b,
    input  o_wr_data_a, o_wr_data_b, o_clear_done, o_addr_err
  );

  // Scheduler side.
  modport slave (
    input  i_req_valid, i_req_addr, i_req_data,
    output o_req_ready, o_wen, o_wr_addr_a, o_wr_addr_b,
    output o_wr_data_a, o_wr_data_b, o_clear_done, o_addr_err
  );
endinterface

// File: rtl/zap_regf_pick2.sv
// Combinational two-of-three picker: chooses up to two in-range requests in
// priority order, never pairing two requests that target the same register.
module zap_regf_pick2
  import zap_regf_sched_pkg::*;
#(
  parameter int NUM_REGS = 40
) (
  input  logic [NUM_REQ-1:0]        valid_i,
  input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
  input  logic                      promote_i,
  output logic [NUM_REQ-1:0]        first_o,
  output logic [NUM_REQ-1:0]        second_o,
  output logic                      first_vld_o,
  output logic                      second_vld_o,
  output logic [NUM_REQ-1:0]        oor_o
);

  logic [NUM_REQ-1:0] elig;
  logic [1:0]         order [NUM_REQ];
  logic [ADDR_W-1:0]  first_addr;

  // Walk requesters in priority order; the second pick skips the first's address.
  always_comb begin
    first_o      = '0;
    second_o     = '0;
    first_vld_o  = 1'b0;
    second_vld_o = 1'b0;
    first_addr   = '0;
    oor_o        = '0;
    elig         = '0;
    // Promotion lifts the base-update requester above load and ALU.
    order[0] = promote_i ? 2'(REQ_BASE) : 2'(REQ_LOAD);
    order[1] = promote_i ? 2'(REQ_LOAD) : 2'(REQ_ALU);
    order[2] = promote_i ? 2'(REQ_ALU)  : 2'(REQ_BASE);
    for (int n = 0; n < NUM_REQ; n++) begin
      oor_o[n] = valid_i[n] &&
                 !({1'b0, addr_i[n*ADDR_W +: ADDR_W]} < (ADDR_W+1)'(NUM_REGS));
      elig[n]  = valid_i[n] && !oor_o[n];
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (elig[order[k]] && !first_vld_o) begin
        first_o[order[k]] = 1'b1;
        first_vld_o       = 1'b1;
        first_addr        = addr_i[order[k]*ADDR_W +: ADDR_W];
      end else if (elig[order[k]] && !second_vld_o &&
                   (addr_i[order[k]*ADDR_W +: ADDR_W] != first_addr)) begin
        second_o[order[k]] = 1'b1;
        second_vld_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/zap_regf_wb_scheduler.sv
// Write-back scheduler: zero-fills the register file after reset or on
// request, then shares the two write ports among load, ALU and base-update.
module zap_regf_wb_scheduler
  import zap_regf_sched_pkg::*;
#(
  parameter int NUM_REGS     = 40,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_clear,
  zap_regf_wb_scheduler_if.slave  bus
);

  logic [0:0]        state_q,   state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [CNT_W-1:0]  starve_q,  starve_d;
  logic              wen_q,     wen_d;
  logic [ADDR_W-1:0] addr_a_q,  addr_a_d;
  logic [ADDR_W-1:0] addr_b_q,  addr_b_d;
  logic [DATA_W-1:0] data_a_q,  data_a_d;
  logic [DATA_W-1:0] data_b_q,  data_b_d;
  logic              err_q,     err_d;

  logic [NUM_REQ-1:0] first, second, oor;
  logic               first_vld, second_vld, promote;
  logic [ADDR_W-1:0]  first_addr, second_addr;
  logic [DATA_W-1:0]  first_data, second_data;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= CNT_W'(STARVE_LIMIT)) ? v : v + 1'b1;
  endfunction

  assign promote = (starve_q == CNT_W'(STARVE_LIMIT));

  zap_regf_pick2 #(.NUM_REGS(NUM_REGS)) u_pick (
    .valid_i      (bus.i_req_valid),
    .addr_i       (bus.i_req_addr),
    .promote_i    (promote),
    .first_o      (first),
    .second_o     (second),
    .first_vld_o  (first_vld),
    .second_vld_o (second_vld),
    .oor_o        (oor)
  );

  // Route the one-hot picks to address/data words.
  always_comb begin
    first_addr  = '0;
    second_addr = '0;
    first_data  = '0;
    second_data = '0;
    for (int n = 0; n < NUM_REQ; n++) begin
      if (first[n]) begin
        first_addr = bus.i_req_addr[n*ADDR_W +: ADDR_W];
        first_data = bus.i_req_data[n*DATA_W +: DATA_W];
      end
      if (second[n]) begin
        second_addr = bus.i_req_addr[n*ADDR_W +: ADDR_W];
        second_data = bus.i_req_data[n*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state: zero-fill pairs in CLEAR, scheduled writes in RUN.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    starve_d  = starve_q;
    wen_d     = 1'b0;
    addr_a_d  = addr_a_q;
    addr_b_d  = addr_b_q;
    data_a_d  = data_a_q;
    data_b_d  = data_b_q;
    err_d     = 1'b0;
    if (state_q == ST_CLEAR) begin
      wen_d     = 1'b1;
      addr_a_d  = clr_ptr_q;
      addr_b_d  = clr_ptr_q + 6'd1;
      data_a_d  = '0;
      data_b_d  = '0;
      clr_ptr_d = clr_ptr_q + 6'd2;
      if (({1'b0, clr_ptr_q} + 7'd2) == 7'(NUM_REGS)) state_d = ST_RUN;
    end else begin
      err_d = |oor;
      if (first_vld) begin
        // First pick lands on port B so it wins any in-file collision.
        wen_d    = 1'b1;
        addr_b_d = first_addr;
        data_b_d = first_data;
        addr_a_d = second_vld ? second_addr : first_addr;
        data_a_d = second_vld ? second_data : first_data;
      end
      if (!bus.i_req_valid[REQ_BASE] || first[REQ_BASE] || second[REQ_BASE])
        starve_d = '0;
      else if (!oor[REQ_BASE])
        starve_d = sat_inc(starve_q);
    end
    if (i_clear) begin
      state_d   = ST_CLEAR;
      clr_ptr_d = '0;
    end
  end

  // State and output registers; reset restarts the clear sequence.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= '0;
      starve_q  <= '0;
      wen_q     <= 1'b0;
      addr_a_q  <= '0;
      addr_b_q  <= '0;
      data_a_q  <= '0;
      data_b_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      starve_q  <= starve_d;
      wen_q     <= wen_d;
      addr_a_q  <= addr_a_d;
      addr_b_q  <= addr_b_d;
      data_a_q  <= data_a_d;
      data_b_q  <= data_b_d;
      err_q     <= err_d;
    end
  end

  assign bus.o_req_ready  = (state_q == ST_RUN) ? (first | second | oor) : '0;
  assign bus.o_clear_done = (state_q == ST_RUN);
  assign bus.o_wen        = wen_q;
  assign bus.o_wr_addr_a  = addr_a_q;
  assign bus.o_wr_addr_b  = addr_b_q;
  assign bus.o_wr_data_a  = data_a_q;
  assign bus.o_wr_data_b  = data_b_q;
  assign bus.o_addr_err   = err_q;

endmodule

// File: tb/tb_zap_regf_wb_scheduler.sv
// Bench for the write-back scheduler: directed scenarios plus a randomized
// run against a cycle-level reference model of the scheduling rules.
module tb_zap_regf_wb_scheduler;
  localparam int NUM_REGS     = 40;
  localparam int STARVE_LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  zap_regf_wb_scheduler_if bus ();

  zap_regf_wb_scheduler #(.NUM_REGS(NUM_REGS), .STARVE_LIMIT(STARVE_LIMIT), .CNT_W(3)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .i_clear (clr),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit          m_run;
  int          m_clr_pairs;
  int          m_starve;
  logic [2:0]  exp_ready, obs_ready;
  logic        exp_wen, exp_err, exp_done;
  logic [5:0]  exp_addr_a, exp_addr_b;
  logic [31:0] exp_data_a, exp_data_b;

  function automatic int ra(input int n);
    return int'(bus.i_req_addr[6*n +: 6]);
  endfunction

  function automatic logic [31:0] rd(input int n);
    return bus.i_req_data[32*n +: 32];
  endfunction

  // One clock: sample ready mid-cycle, advance the model, land #1 after the edge.
  task automatic tick();
    int pr[3];
    int f, s;
    logic [2:0] rdy, oor;
    @(negedge clk);
    obs_ready = bus.o_req_ready;
    f = -1; s = -1; rdy = '0; oor = '0;
    if (m_run) begin
      if (m_starve == STARVE_LIMIT) pr = '{2, 0, 1};
      else pr = '{0, 1, 2};
      for (int n = 0; n < 3; n++)
        if (bus.i_req_valid[n] && ra(n) >= NUM_REGS) oor[n] = 1'b1;
      for (int k = 0; k < 3; k++) begin
        if (bus.i_req_valid[pr[k]] && !oor[pr[k]]) begin
          if (f < 0) f = pr[k];
          else if (s < 0 && ra(pr[k]) != ra(f)) s = pr[k];
        end
      end
      rdy = oor;
      if (f >= 0) rdy[f] = 1'b1;
      if (s >= 0) rdy[s] = 1'b1;
    end
    exp_ready = rdy;
    if (m_run) begin
      exp_err = |oor;
      exp_wen = (f >= 0);
      if (f >= 0) begin
        exp_addr_b = 6'(ra(f));
        exp_data_b = rd(f);
        exp_addr_a = (s >= 0) ? 6'(ra(s)) : 6'(ra(f));
        exp_data_a = (s >= 0) ? rd(s) : rd(f);
      end
      if (!bus.i_req_valid[2] || (rdy[2] && !oor[2])) m_starve = 0;
      else if (!oor[2] && m_starve < STARVE_LIMIT) m_starve++;
    end else begin
      exp_err    = 1'b0;
      exp_wen    = 1'b1;
      exp_addr_a = 6'(2 * m_clr_pairs);
      exp_addr_b = 6'(2 * m_clr_pairs + 1);
      exp_data_a = '0;
      exp_data_b = '0;
      m_clr_pairs++;
      if (m_clr_pairs == NUM_REGS / 2) begin
        m_run = 1'b1;
        m_clr_pairs = 0;
      end
    end
    if (clr) begin
      m_run = 1'b0;
      m_clr_pairs = 0;
    end
    exp_done = m_run;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int n, input logic v, input int a, input logic [31:0] d);
    bus.i_req_valid[n]       = v;
    bus.i_req_addr[6*n +: 6] = 6'(a);
    bus.i_req_data[32*n +: 32] = d;
  endtask

  task automatic test_reset();
    bus.i_req_valid = '0;
    bus.i_req_addr  = '0;
    bus.i_req_data  = '0;
    clr = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_run = 1'b0; m_clr_pairs = 0; m_starve = 0;
    exp_wen = 1'b0; exp_err = 1'b0; exp_done = 1'b0;
    exp_addr_a = '0; exp_addr_b = '0; exp_data_a = '0; exp_data_b = '0;
    n_vec++;
    if ({bus.o_wen, bus.o_clear_done, bus.o_addr_err, bus.o_req_ready} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {bus.o_wen, bus.o_clear_done, bus.o_addr_err, bus.o_req_ready});
    end
    n_vec++;
    if ({bus.o_wr_addr_a, bus.o_wr_addr_b, bus.o_wr_data_a, bus.o_wr_data_b} !== 76'b0) begin
      n_err++;
      $display("FAIL reset_bus: got %h expected 0",
               {bus.o_wr_addr_a, bus.o_wr_addr_b, bus.o_wr_data_a, bus.o_wr_data_b});
    end
    for (int k = 0; k < NUM_REGS / 2; k++) begin
      tick();
      n_vec++;
      if (bus.o_wen !== 1'b1 || bus.o_wr_addr_a !== 6'(2*k) || bus.o_wr_addr_b !== 6'(2*k+1) ||
          bus.o_wr_data_a !== 32'h0 || bus.o_wr_data_b !== 32'h0 || obs_ready !== 3'b0) begin
        n_err++;
        $display("FAIL clear_pair %0d: got wen=%b a=%0d b=%0d rdy=%b expected wen=1 a=%0d b=%0d rdy=000",
                 k, bus.o_wen, bus.o_wr_addr_a, bus.o_wr_addr_b, obs_ready, 2*k, 2*k+1);
      end
      n_vec++;
      if (bus.o_clear_done !== (k == NUM_REGS / 2 - 1)) begin
        n_err++;
        $display("FAIL clear_done %0d: got %b expected %b", k, bus.o_clear_done, k == NUM_REGS / 2 - 1);
      end
    end
    tick();
    n_vec++;
    if (bus.o_wen !== 1'b0 || bus.o_clear_done !== 1'b1) begin
      n_err++;
      $display("FAIL idle_run: got wen=%b done=%b expected wen=0 done=1", bus.o_wen, bus.o_clear_done);
    end
  endtask

  task automatic test_dual_write();
    set_req(0, 1'b1, 5, 32'hAAAA_0000);
    set_req(1, 1'b1, 7, 32'h0000_1234);
    tick();
    n_vec++;
    if (obs_ready !== 3'b011) begin
      n_err++;
      $display("FAIL dual_ready: got %b expected 011", obs_ready);
    end
    n_vec++;
    if (bus.o_wen !== 1'b1 || bus.o_wr_addr_b !== 6'd5 || bus.o_wr_data_b !== 32'hAAAA_0000 ||
        bus.o_wr_addr_a !== 6'd7 || bus.o_wr_data_a !== 32'h0000_1234) begin
      n_err++;
      $display("FAIL dual_ports: got wen=%b B=(%0d,%h) A=(%0d,%h) expected 1 B=(5,aaaa0000) A=(7,00001234)",
               bus.o_wen, bus.o_wr_addr_b, bus.o_wr_data_b, bus.o_wr_addr_a, bus.o_wr_data_a);
    end
    bus.i_req_valid = '0;
    tick();
    n_vec++;
    if (bus.o_wen !== 1'b0 || bus.o_wr_addr_b !== 6'd5) begin
      n_err++;
      $display("FAIL dual_idle_hold: got wen=%b B=%0d expected wen=0 B=5", bus.o_wen, bus.o_wr_addr_b);
    end
  endtask

  task automatic test_same_addr();
    set_req(0, 1'b1, 9, 32'h1111_2222);
    set_req(1, 1'b1, 9, 32'h3333_4444);
    tick();
    n_vec++;
    if (obs_ready !== 3'b001 || bus.o_wen !== 1'b1 || bus.o_wr_addr_a !== 6'd9 || bus.o_wr_addr_b !== 6'd9 ||
        bus.o_wr_data_a !== 32'h1111_2222 || bus.o_wr_data_b !== 32'h1111_2222) begin
      n_err++;
      $display("FAIL same_addr_first: got rdy=%b A=(%0d,%h) B=(%0d,%h) expected 001 both (9,11112222)",
               obs_ready, bus.o_wr_addr_a, bus.o_wr_data_a, bus.o_wr_addr_b, bus.o_wr_data_b);
    end
    bus.i_req_valid[0] = 1'b0;
    tick();
    n_vec++;
    if (obs_ready !== 3'b010 || bus.o_wen !== 1'b1 ||
        bus.o_wr_data_a !== 32'h3333_4444 || bus.o_wr_data_b !== 32'h3333_4444) begin
      n_err++;
      $display("FAIL same_addr_second: got rdy=%b A=%h B=%h expected 010 both 33334444",
               obs_ready, bus.o_wr_data_a, bus.o_wr_data_b);
    end
    bus.i_req_valid = '0;
    tick();
  endtask

  task automatic test_starvation();
    set_req(0, 1'b1, 1, 32'hA0);
    set_req(1, 1'b1, 2, 32'hA1);
    set_req(2, 1'b1, 3, 32'hA2);
    for (int k = 0; k < STARVE_LIMIT; k++) begin
      tick();
      n_vec++;
      if (obs_ready !== 3'b011) begin
        n_err++;
        $display("FAIL starve_deny %0d: got %b expected 011", k, obs_ready);
      end
    end
    tick();
    n_vec++;
    if (obs_ready !== 3'b101 || bus.o_wr_addr_b !== 6'd3 || bus.o_wr_data_b !== 32'hA2 ||
        bus.o_wr_addr_a !== 6'd1) begin
      n_err++;
      $display("FAIL starve_promote: got rdy=%b B=(%0d,%h) A=%0d expected 101 B=(3,a2) A=1",
               obs_ready, bus.o_wr_addr_b, bus.o_wr_data_b, bus.o_wr_addr_a);
    end
    tick();
    n_vec++;
    if (obs_ready !== 3'b011) begin
      n_err++;
      $display("FAIL starve_reset: got %b expected 011", obs_ready);
    end
    bus.i_req_valid = '0;
    tick();
  endtask

  task automatic test_addr_err();
    set_req(0, 1'b1, 10, 32'hBEEF);
    set_req(1, 1'b1, 45, 32'hDEAD);
    tick();
    n_vec++;
    if (obs_ready !== 3'b011 || bus.o_addr_err !== 1'b1) begin
      n_err++;
      $display("FAIL addr_err_flag: got rdy=%b err=%b expected 011 err=1", obs_ready, bus.o_addr_err);
    end
    n_vec++;
    if (bus.o_wen !== 1'b1 || bus.o_wr_addr_a !== 6'd10 || bus.o_wr_addr_b !== 6'd10 ||
        bus.o_wr_data_a !== 32'hBEEF || bus.o_wr_data_b !== 32'hBEEF) begin
      n_err++;
      $display("FAIL addr_err_write: got A=(%0d,%h) B=(%0d,%h) expected both (10,beef)",
               bus.o_wr_addr_a, bus.o_wr_data_a, bus.o_wr_addr_b, bus.o_wr_data_b);
    end
    bus.i_req_valid = '0;
    tick();
    n_vec++;
    if (bus.o_addr_err !== 1'b0) begin
      n_err++;
      $display("FAIL addr_err_pulse: got %b expected 0", bus.o_addr_err);
    end
  endtask

  task automatic test_clear_rerun();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_vec++;
    if (bus.o_clear_done !== 1'b0) begin
      n_err++;
      $display("FAIL clear_drop: got %b expected 0", bus.o_clear_done);
    end
    set_req(0, 1'b1, 12, 32'hC0DE);
    for (int k = 0; k < NUM_REGS / 2; k++) begin
      tick();
      n_vec++;
      if (obs_ready !== 3'b000 || bus.o_wen !== 1'b1 || bus.o_wr_addr_a !== 6'(2*k) ||
          bus.o_wr_data_b !== 32'h0) begin
        n_err++;
        $display("FAIL rerun_pair %0d: got rdy=%b wen=%b a=%0d expected 000 1 %0d",
                 k, obs_ready, bus.o_wen, bus.o_wr_addr_a, 2*k);
      end
    end
    tick();
    n_vec++;
    if (obs_ready !== 3'b001 || bus.o_wr_addr_b !== 6'd12 || bus.o_wr_data_b !== 32'hC0DE) begin
      n_err++;
      $display("FAIL rerun_grant: got rdy=%b B=(%0d,%h) expected 001 (12,c0de)",
               obs_ready, bus.o_wr_addr_b, bus.o_wr_data_b);
    end
    bus.i_req_valid = '0;
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      clr = ($urandom_range(0, 59) == 0);
      tick();
      n_vec++;
      if (obs_ready !== exp_ready) begin
        n_err++;
        $display("FAIL rnd_ready c%0d: got %b expected %b", c, obs_ready, exp_ready);
      end
      n_vec++;
      if (bus.o_wen !== exp_wen || bus.o_wr_addr_a !== exp_addr_a || bus.o_wr_addr_b !== exp_addr_b ||
          bus.o_wr_data_a !== exp_data_a || bus.o_wr_data_b !== exp_data_b) begin
        n_err++;
        $display("FAIL rnd_bus c%0d: got %b A=(%0d,%h) B=(%0d,%h) expected %b A=(%0d,%h) B=(%0d,%h)", c,
                 bus.o_wen, bus.o_wr_addr_a, bus.o_wr_data_a, bus.o_wr_addr_b, bus.o_wr_data_b,
                 exp_wen, exp_addr_a, exp_data_a, exp_addr_b, exp_data_b);
      end
      n_vec++;
      if (bus.o_addr_err !== exp_err || bus.o_clear_done !== exp_done) begin
        n_err++;
        $display("FAIL rnd_flags c%0d: got err=%b done=%b expected err=%b done=%b",
                 c, bus.o_addr_err, bus.o_clear_done, exp_err, exp_done);
      end
      for (int n = 0; n < 3; n++) begin
        if (!bus.i_req_valid[n] || exp_ready[n]) begin
          set_req(n, ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 9) == 0) ? 40 + $urandom_range(0, 23) : $urandom_range(0, 5),
                  $urandom);
        end
      end
    end
    clr = 1'b0;
    bus.i_req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_dual_write();
    test_same_addr();
    test_starvation();
    test_addr_err();
    test_clear_rerun();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
